conv_window_gen: RTL and testbench
==================================

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 32, meaning image width in pixels (IMG_W >= 5).
REQ-002 SHALL have parameter IMG_H, default 32, meaning image height in pixels (IMG_H >= 5).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port pix_in, input, 8, unsigned pixel, row-major raster order.
REQ-006 SHALL have port pix_valid, input, 1, pix_in valid.
REQ-007 SHALL have port pix_ready, output, 1, pixel accepted when pix_valid && pix_ready at clk edge.
REQ-008 SHALL have port window, output, [4:0][4:0] x 8, 5x5 window to the conv stage.
REQ-009 SHALL have port conv_start, output, 1, one-cycle start pulse to the conv stage.
REQ-010 SHALL have port conv_done, input, 1, one-cycle completion pulse from the conv stage.
REQ-011 SHALL have ports win_row and win_col, output, 16 each, top-left output coordinate of the current window.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse after the last window of a frame completes.

Function
REQ-013 SHALL track the accepted pixel position with row r in 0..IMG_H-1 and column c in 0..IMG_W-1; c wraps to 0 and r increments after c = IMG_W-1.
REQ-014 SHALL keep 4 line buffers of IMG_W x 8 bits holding rows r-1..r-4.
REQ-015 SHALL, on each accepted pixel, shift every window row one column toward index 0 and load column 4 as follows: window[4][4] = pix_in; window[i][4] = pixel (r-4+i, c) for i = 0..3.
REQ-016 SHALL satisfy window[i][j] = pixel (r-4+i, c-4+j) whenever a window is issued.
REQ-017 SHALL implement FSM states ACCEPT, ISSUE and WAIT; the reset state is ACCEPT.
REQ-018 SHALL drive pix_ready = 1 only in ACCEPT.
REQ-019 SHALL, in ACCEPT, move to ISSUE on an accepted pixel with r >= 4 and c >= 4, and otherwise stay in ACCEPT.
REQ-020 SHALL, in ISSUE, assert conv_start for exactly one cycle, set win_row = r-4 and win_col = c-4, and move to WAIT.
REQ-021 SHALL, in WAIT, move to ACCEPT on conv_done.
REQ-022 SHALL hold window, win_row and win_col stable from ISSUE until the cycle after conv_done.
REQ-023 SHALL ignore conv_done in ACCEPT and ISSUE.
REQ-024 SHALL ignore pix_valid outside ACCEPT.
REQ-025 SHALL, on conv_done for the window at r = IMG_H-1, c = IMG_W-1, pulse frame_done in the following cycle and reset r and c to 0.
REQ-026 SHALL issue exactly (IMG_H-4)*(IMG_W-4) windows per frame, and SHALL NOT issue windows whose span wraps across a row edge.
REQ-027 SHALL have a latency of one cycle from the qualifying pixel handshake to conv_start.

Reset
REQ-028 SHALL, on rst assertion regardless of state, immediately set state = ACCEPT, r = c = 0, window all zeros, conv_start = 0, frame_done = 0, win_row = win_col = 0, and pix_ready = 0 while rst is high.
REQ-029 SHALL leave line-buffer contents unreset (don't-care), because no window is issued before rows 0..3 are refilled.

Structure
REQ-030 SHALL place K = 5, DW = 8 and the FSM state enum in a shared package conv_pkg, which is also used by the conv stage.
REQ-031 SHALL instantiate sub-module line_buffer (IMG_W-deep, 8-bit, circular read-before-write) four times.

Verification
REQ-032 SHALL cover basic fill: IMG_W = IMG_H = 8, pixel = 8r+c, conv_done returned 25 cycles after each start -> first conv_start the cycle after pixel 36 is accepted, window[0][0] = 0, window[4][4] = 36, window[2][3] = 19.
REQ-033 SHALL cover frame count: full 8x8 frame -> exactly 16 conv_start pulses, win_col sequence 0..3 per row, one frame_done after the 16th conv_done.
REQ-034 SHALL cover backpressure: conv_done withheld 100 cycles with pix_valid high throughout -> pix_ready = 0 and window unchanged for all 100 cycles.
REQ-035 SHALL cover spurious handshakes: conv_done pulsed in ACCEPT -> no state change; pix_valid asserted in WAIT -> no pixel consumed.
REQ-036 SHALL cover reset mid-WAIT: rst asserted, then a new 8x8 frame sent -> first window is again pixels 0..36 with no stale data, and 16 windows are issued.
REQ-037 SHALL cover back-to-back frames: two frames sent with no gap -> 32 windows total, with the second frame's window[0][0] = 0 at win_row = win_col = 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the window generator and the conv stage.
package conv_pkg;
    localparam int K  = 5;
    localparam int DW = 8;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2
    } state_t;

    typedef logic [K-1:0][K-1:0][DW-1:0] window_t;
endpackage

// File: rtl/line_buffer.sv
// One image row of storage: circular buffer, read-before-write at a self-advancing pointer.
module line_buffer #(
    parameter int DEPTH = 32,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ptr_q, ptr_d;

    // Data read at ptr is the value written exactly DEPTH writes ago.
    assign rdata = mem[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (we) ptr_d = (ptr_q == AW'(DEPTH-1)) ? '0 : ptr_q + AW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    always_ff @(posedge clk) begin
        if (we) mem[ptr_q] <= wdata;
    end
endmodule

// File: rtl/conv_window_gen.sv
// Streams raster pixels into four line buffers and hands 5x5 windows to a conv stage
// with a start/done handshake, stalling input while the conv stage is busy.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DW-1:0]                pix_in,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    output logic [K-1:0][K-1:0][DW-1:0]  window,
    output logic                         conv_start,
    input  logic                         conv_done,
    output logic [15:0]                  win_row,
    output logic [15:0]                  win_col,
    output logic                         frame_done
);
    state_t          state_q, state_d;
    logic [15:0]     r_q, r_d, c_q, c_d;
    logic [15:0]     win_row_q, win_row_d, win_col_q, win_col_d;
    logic            last_q, last_d;
    logic            frame_done_q, frame_done_d;
    logic            en_q;
    window_t         win_q, win_d;
    logic [3:0][DW-1:0] lb_rd, lb_wd;
    logic            accept;

    // en_q keeps ready low while reset is held and releases it on the first edge after.
    assign pix_ready  = (state_q == ACCEPT) && en_q;
    assign accept     = pix_valid && pix_ready;
    assign conv_start = (state_q == ISSUE);
    assign window     = win_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;

    // Buffer g holds row r-1-g; each row cascades down one buffer per line.
    always_comb begin
        lb_wd[0] = pix_in;
        for (int g = 1; g < 4; g++) lb_wd[g] = lb_rd[g-1];
    end

    for (genvar g = 0; g < 4; g++) begin : g_lb
        line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb (
            .clk   (clk),
            .rst   (rst),
            .we    (accept),
            .wdata (lb_wd[g]),
            .rdata (lb_rd[g])
        );
    end

    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        c_d          = c_q;
        win_d        = win_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        last_d       = last_q;
        frame_done_d = 1'b0;
        case (state_q)
            ACCEPT: begin
                if (accept) begin
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K-1; j++)
                            win_d[i][j] = win_q[i][j+1];
                    for (int i = 0; i < K-1; i++) win_d[i][K-1] = lb_rd[3-i];
                    win_d[K-1][K-1] = pix_in;
                    if (c_q == 16'(IMG_W-1)) begin
                        c_d = '0;
                        r_d = (r_q == 16'(IMG_H-1)) ? '0 : r_q + 16'd1;
                    end else begin
                        c_d = c_q + 16'd1;
                    end
                    // Requiring c >= 4 keeps every window inside a single row span.
                    if (r_q >= 16'd4 && c_q >= 16'd4) begin
                        state_d   = ISSUE;
                        win_row_d = r_q - 16'd4;
                        win_col_d = c_q - 16'd4;
                        last_d    = (r_q == 16'(IMG_H-1)) && (c_q == 16'(IMG_W-1));
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (conv_done) begin
                    state_d      = ACCEPT;
                    frame_done_d = last_q;
                    last_d       = 1'b0;
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ACCEPT;
            r_q          <= '0;
            c_q          <= '0;
            win_q        <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            en_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            c_q          <= c_d;
            win_q        <= win_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
            en_q         <= 1'b1;
        end
    end
endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized 8x8 frame streams checked against an image-array model of every issued window.
module tb_conv_window_gen;
    localparam int W = 8, H = 8, FR = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] pix_in = '0;
    logic pix_valid = 1'b0;
    logic pix_ready;
    logic [4:0][4:0][7:0] window;
    logic conv_start;
    logic conv_done = 1'b0;
    logic [15:0] win_row, win_col;
    logic frame_done;

    int checks = 0;
    int errors = 0;
    logic [7:0] stream[$];
    logic [4:0][4:0][7:0] first_win;
    logic [15:0] first_row, first_col;

    always #5 clk = ~clk;

    conv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .window     (window),
        .conv_start (conv_start),
        .conv_done  (conv_done),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Window whose bottom-right pixel is stream index p, taken straight from the image.
    function automatic logic [4:0][4:0][7:0] model_win(input int p);
        logic [4:0][4:0][7:0] m;
        int base, r, c;
        base = p - p % FR;
        r = (p % FR) / W;
        c = p % W;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                m[i][j] = stream[base + (r - 4 + i) * W + (c - 4 + j)];
        return m;
    endfunction

    task automatic run_stream(input int nframes, input int lat_min, input int lat_max, input int vpct);
        int idx = 0, nwin = 0, cnt = 0, cyc = 0, p = 0, fd_cnt = 0;
        int total = nframes * FR;
        bit hs, done_now, exp_start;
        bit in_wait = 1'b0, last_pend = 1'b0;
        logic [4:0][4:0][7:0] hold = '0;
        pix_valid = 1'b1;
        pix_in = stream[0];
        while ((idx < total || in_wait || conv_done) && cyc < 40000) begin
            @(negedge clk);
            hs = pix_valid && pix_ready;
            @(posedge clk);
            #1;
            cyc++;
            done_now = conv_done;
            conv_done = 1'b0;
            chk("frame_done", frame_done, done_now && last_pend);
            fd_cnt += int'(frame_done);
            if (done_now) begin
                last_pend = 1'b0;
                chk("hold_after_done", window, hold);
            end
            exp_start = 1'b0;
            if (hs) begin
                p = idx;
                idx++;
                exp_start = ((p % FR) / W >= 4) && (p % W >= 4);
            end
            chk("conv_start", conv_start, exp_start);
            if (exp_start) begin
                chk("win_row", win_row, (p % FR) / W - 4);
                chk("win_col", win_col, p % W - 4);
                chk("window", window, model_win(p));
                if (p % FR == 4 * W + 4) begin
                    first_win = window;
                    first_row = win_row;
                    first_col = win_col;
                end
                hold = window;
                nwin++;
                last_pend = (p % FR == FR - 1);
                in_wait = 1'b1;
                cnt = int'($urandom_range(lat_max, lat_min));
            end else if (in_wait) begin
                chk("wait_ready", pix_ready, 1'b0);
                chk("wait_window", window, hold);
                cnt--;
                if (cnt <= 0) begin
                    conv_done = 1'b1;
                    in_wait = 1'b0;
                end
            end
            if (idx < total) begin
                pix_valid = ($urandom_range(99) < vpct);
                pix_in = pix_valid ? stream[idx] : 8'($urandom);
            end else begin
                pix_valid = 1'b0;
            end
        end
        chk("pixels_consumed", idx, total);
        chk("window_count", nwin, nframes * 16);
        chk("frame_done_count", fd_cnt, nframes);
    endtask

    task automatic fill_random(input int nframes);
        stream.delete();
        for (int k = 0; k < nframes * FR; k++) stream.push_back(8'($urandom));
    endtask

    initial begin
        int idx;
        bit hs;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", pix_ready, 1'b0);
        chk("rst_start", conv_start, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_window", window, '0);
        chk("rst_win_row", win_row, 16'd0);
        chk("rst_win_col", win_col, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic fill with pixel = 8r+c and a fixed 25-cycle conv latency.
        stream.delete();
        for (int k = 0; k < FR; k++) stream.push_back(8'(k));
        run_stream(1, 25, 25, 100);
        stream.delete();
        chk("fill_w00", first_win[0][0], 8'd0);
        chk("fill_w44", first_win[4][4], 8'd36);
        chk("fill_w23", first_win[2][3], 8'd19);
        chk("fill_row", first_row, 16'd0);
        chk("fill_col", first_col, 16'd0);

        // Backpressure: conv_done held off ~100 cycles with pix_valid high.
        fill_random(1);
        run_stream(1, 101, 101, 100);

        // Spurious conv_done while accepting.
        conv_done = 1'b1;
        @(posedge clk);
        #1;
        conv_done = 1'b0;
        chk("spur_ready", pix_ready, 1'b1);
        chk("spur_start", conv_start, 1'b0);
        chk("spur_frame_done", frame_done, 1'b0);
        @(posedge clk);
        #1;
        chk("spur_start2", conv_start, 1'b0);

        // Random valid gaps and short random latencies.
        fill_random(1);
        run_stream(1, 1, 6, 60);

        // Reset while waiting on the conv stage.
        fill_random(1);
        idx = 0;
        pix_valid = 1'b1;
        pix_in = stream[0];
        for (int k = 0; k < 200 && !conv_start; k++) begin
            @(negedge clk);
            hs = pix_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                idx++;
                pix_in = stream[idx];
            end
        end
        chk("pre_reset_start", conv_start, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", pix_ready, 1'b0);
        chk("mid_rst_window", window, '0);
        chk("mid_rst_start", conv_start, 1'b0);
        chk("mid_rst_row", win_row, 16'd0);
        chk("mid_rst_col", win_col, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        pix_valid = 1'b0;
        fill_random(1);
        run_stream(1, 2, 30, 100);

        // Back-to-back frames: random first frame, 8r+c second frame.
        fill_random(1);
        for (int k = 0; k < FR; k++) stream.push_back(8'(k));
        run_stream(2, 1, 8, 100);
        chk("b2b_w00", first_win[0][0], 8'd0);
        chk("b2b_w44", first_win[4][4], 8'd36);
        chk("b2b_row", first_row, 16'd0);
        chk("b2b_col", first_col, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
